// File: rtl/blit_pkg.sv
// ----------------------------------------------------------------------------
// blit_pkg
// Shared types and default sizes for the blitter write path.
//   blit_wr_t              : one byte-masked word write {addr, data, be}
//   BLIT_WQ_DEPTH_LOG2_DEF : default log2 depth of the write queue
// Widths inside blit_wr_t match the default parameters of blit_write_queue.
// ----------------------------------------------------------------------------
package blit_pkg;

    localparam int BLIT_ADDR_W_DEF         = 26;
    localparam int BLIT_DATA_W_DEF         = 32;
    localparam int BLIT_BE_W_DEF           = BLIT_DATA_W_DEF / 8;
    localparam int BLIT_WQ_DEPTH_LOG2_DEF  = 8;
    localparam int BLIT_WQ_FULL_MARGIN_DEF = 8;

    typedef struct packed {
        logic [BLIT_ADDR_W_DEF-1:0] addr;
        logic [BLIT_DATA_W_DEF-1:0] data;
        logic [BLIT_BE_W_DEF-1:0]   be;
    } blit_wr_t;

endpackage

// File: rtl/blit_wq_ram.sv
// ----------------------------------------------------------------------------
// blit_wq_ram
// Simple dual-port RAM backing the write queue: one write port, one
// synchronous read port. A read of the address being written in the same
// cycle returns the previous contents.
// Ports:
//   clock    : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address, sampled every cycle
//   rd_data  : registered read data (valid the cycle after rd_addr)
// ----------------------------------------------------------------------------
module blit_wq_ram
    import blit_pkg::*;
#(
    parameter int WIDTH  = $bits(blit_wr_t),
    parameter int ADDR_W = BLIT_WQ_DEPTH_LOG2_DEF
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Synchronous read port; old data on a same-address collision.
    always_ff @(posedge clock) begin
        rd_data <= mem_r[rd_addr];
    end

endmodule

// File: rtl/blit_write_queue.sv
// ----------------------------------------------------------------------------
// blit_write_queue
// Write queue between the blitter pixel pipeline and the memory arbiter.
// Buffers byte-masked word writes in a circular buffer (one slot always kept
// empty) and presents the head on a registered req/ack port. fifo_full is an
// early-full warning so the pipeline can stop with writes still in flight.
//
// Optional feature, macro BLIT_WQ_COMBINE_EN: a one-entry staging register in
// front of the queue merges consecutive writes to the same word address.
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   in_write/addr/data/
//   in_byte_enable          : push one write (no handshake; not while full)
//   fifo_full               : free entries < FULL_MARGIN (combinational)
//   out_req/addr/data/
//   out_byte_enable         : registered head of queue
//   out_ack                 : arbiter accepts the head
//   level                   : entries held, including the presented head
//   idle                    : empty, no request, nothing staged
//   overflow                : sticky, a push was dropped for lack of space
// ----------------------------------------------------------------------------
module blit_write_queue
    import blit_pkg::*;
#(
    parameter int ADDR_W      = BLIT_ADDR_W_DEF,
    parameter int DATA_W      = BLIT_DATA_W_DEF,
    parameter int DEPTH_LOG2  = BLIT_WQ_DEPTH_LOG2_DEF,
    parameter int FULL_MARGIN = BLIT_WQ_FULL_MARGIN_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_write,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [DATA_W/8-1:0]   in_byte_enable,
    output logic                  fifo_full,
    output logic                  out_req,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [DATA_W-1:0]     out_data,
    output logic [DATA_W/8-1:0]   out_byte_enable,
    input  logic                  out_ack,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  idle,
    output logic                  overflow
);

    localparam int BE_W    = DATA_W / 8;
    localparam int ENTRY_W = ADDR_W + DATA_W + BE_W;
    localparam logic [DEPTH_LOG2:0] MARGIN = (DEPTH_LOG2 + 1)'(FULL_MARGIN);

    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2-1:0] next_wr_s;
    logic [DEPTH_LOG2-1:0] next_rd_s;
    logic [DEPTH_LOG2-1:0] free_s;
    logic                  push_s;
    logic                  push_ok_s;
    logic                  push_drop_s;
    logic                  pop_s;
    logic                  stage_next_valid_s;
    logic [DEPTH_LOG2:0]   full_limit_s;
    logic [ENTRY_W-1:0]    push_entry_s;
    logic [ENTRY_W-1:0]    rd_entry_s;
    logic                  out_req_r;
    logic [DEPTH_LOG2:0]   level_r;
    logic                  idle_r;
    logic                  overflow_r;

`ifdef BLIT_WQ_COMBINE_EN
    logic                  stg_valid_r;
    logic [ADDR_W-1:0]     stg_addr_r;
    logic [DATA_W-1:0]     stg_data_r;
    logic [BE_W-1:0]       stg_be_r;
    logic                  merge_s;
    logic [DATA_W-1:0]     merged_data_s;

    // Staging control: merge same-address writes, otherwise flush the staged
    // entry into the queue and stage the new write (if any).
    always_comb begin
        merge_s       = in_write & stg_valid_r & (in_addr == stg_addr_r);
        merged_data_s = stg_data_r;
        for (int b = 0; b < BE_W; b++) begin
            if (in_byte_enable[b]) begin
                merged_data_s[8*b +: 8] = in_data[8*b +: 8];
            end else begin
                merged_data_s[8*b +: 8] = stg_data_r[8*b +: 8];
            end
        end
        push_s             = stg_valid_r & ~merge_s;
        push_entry_s       = {stg_addr_r, stg_data_r, stg_be_r};
        // A merge needs in_write, so the staging slot is valid next cycle
        // exactly when a write arrives this cycle.
        stage_next_valid_s = in_write;
        // The staged entry counts as occupying a queue slot.
        full_limit_s       = MARGIN + (DEPTH_LOG2 + 1)'(stg_valid_r);
    end

    // Staging valid flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            stg_valid_r <= 1'b0;
        end else begin
            stg_valid_r <= stage_next_valid_s;
        end
    end

    // Staging payload; meaningless while stg_valid_r is low.
    always_ff @(posedge clock) begin
        if (merge_s) begin
            stg_data_r <= merged_data_s;
            stg_be_r   <= stg_be_r | in_byte_enable;
        end else if (in_write) begin
            stg_addr_r <= in_addr;
            stg_data_r <= in_data;
            stg_be_r   <= in_byte_enable;
        end
    end
`else
    // Writes go straight into the queue.
    always_comb begin
        push_s             = in_write;
        push_entry_s       = {in_addr, in_data, in_byte_enable};
        stage_next_valid_s = 1'b0;
        full_limit_s       = MARGIN;
    end
`endif

    // Pointer arithmetic; free count wraps modulo depth with one slot spare.
    always_comb begin
        free_s      = rd_ptr_r - wr_ptr_r - DEPTH_LOG2'(1);
        push_ok_s   = push_s & (free_s != {DEPTH_LOG2{1'b0}});
        push_drop_s = push_s & (free_s == {DEPTH_LOG2{1'b0}});
        pop_s       = out_ack & out_req_r;
        next_rd_s   = rd_ptr_r + DEPTH_LOG2'(pop_s);
        next_wr_s   = wr_ptr_r + DEPTH_LOG2'(push_ok_s);
        fifo_full   = {1'b0, free_s} < full_limit_s;
    end

    // Pointers, request and status registers. out_req looks at the old write
    // pointer: the RAM read for a just-written slot can only start next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
            out_req_r  <= 1'b0;
            level_r    <= {(DEPTH_LOG2 + 1){1'b0}};
            idle_r     <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r  <= next_wr_s;
            rd_ptr_r  <= next_rd_s;
            out_req_r <= (next_rd_s != wr_ptr_r);
            level_r   <= {1'b0, next_wr_s - next_rd_s};
            idle_r    <= (next_wr_s == next_rd_s) & (next_rd_s == wr_ptr_r)
                         & ~stage_next_valid_s;
            if (push_drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // The RAM read register doubles as the output register: it always holds
    // mem[rd_ptr], which stays stable while the head is not acked.
    blit_wq_ram #(
        .WIDTH  (ENTRY_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clock   (clock),
        .wr_en   (push_ok_s),
        .wr_addr (wr_ptr_r),
        .wr_data (push_entry_s),
        .rd_addr (next_rd_s),
        .rd_data (rd_entry_s)
    );

    assign {out_addr, out_data, out_byte_enable} = rd_entry_s;
    assign out_req  = out_req_r;
    assign level    = level_r;
    assign idle     = idle_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_blit_write_queue.sv
// ----------------------------------------------------------------------------
// tb_blit_write_queue
// Randomised, self-checking bench for blit_write_queue against a queue-based
// reference model. Honours BLIT_WQ_COMBINE_EN when defined.
// ----------------------------------------------------------------------------
module tb_blit_write_queue;
    import blit_pkg::*;

`ifdef BLIT_WQ_COMBINE_EN
    localparam int STG = 1;
`else
    localparam int STG = 0;
`endif

    logic        clock;
    logic        reset;
    logic        in_write;
    logic [25:0] in_addr;
    logic [31:0] in_data;
    logic [3:0]  in_byte_enable;
    logic        fifo_full;
    logic        out_req;
    logic [25:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  out_byte_enable;
    logic        out_ack;
    logic [8:0]  level;
    logic        idle;
    logic        overflow;

    blit_write_queue dut (
        .clock           (clock),
        .reset           (reset),
        .in_write        (in_write),
        .in_addr         (in_addr),
        .in_data         (in_data),
        .in_byte_enable  (in_byte_enable),
        .fifo_full       (fifo_full),
        .out_req         (out_req),
        .out_addr        (out_addr),
        .out_data        (out_data),
        .out_byte_enable (out_byte_enable),
        .out_ack         (out_ack),
        .level           (level),
        .idle            (idle),
        .overflow        (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    blit_wr_t q[$];
    bit       m_req;
    bit       m_ovf;
    bit       m_stg_v;
    blit_wr_t m_stg;

    int n_cmp = 0;
    int n_err = 0;
    int max_level = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_full();
        return (255 - q.size() - int'(m_stg_v)) < 8;
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input bit rst, input bit w, input logic [25:0] a,
                              input logic [31:0] d, input logic [3:0] be, input bit ack);
        blit_wr_t nw;
        blit_wr_t pe;
        bit       push;
        bit       pop;
        int       remain;
        int       free;
        if (rst) begin
            q.delete();
            m_req   = 1'b0;
            m_ovf   = 1'b0;
            m_stg_v = 1'b0;
        end else begin
            nw.addr = a;
            nw.data = d;
            nw.be   = be;
            pe      = nw;
            push    = 1'b0;
`ifdef BLIT_WQ_COMBINE_EN
            if (w && m_stg_v && a == m_stg.addr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_stg.data[8*b +: 8] = d[8*b +: 8];
                m_stg.be = m_stg.be | be;
            end else begin
                push    = m_stg_v;
                pe      = m_stg;
                m_stg_v = w;
                if (w) m_stg = nw;
            end
`else
            push = w;
`endif
            pop    = ack && m_req;
            free   = 255 - q.size();
            remain = q.size() - int'(pop);
            if (pop) void'(q.pop_front());
            if (push) begin
                if (free == 0) m_ovf = 1'b1;
                else q.push_back(pe);
            end
            m_req = (remain != 0);
        end
    endtask

    task automatic check_all();
        check("out_req", 64'(out_req), 64'(m_req));
        check("level", 64'(level), 64'(q.size()));
        check("idle", 64'(idle), 64'(q.size() == 0 && !m_req && !m_stg_v));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("fifo_full", 64'(fifo_full), 64'(model_full()));
        if (m_req)
            check("head", {2'b00, out_addr, out_data, out_byte_enable}, {2'b00, q[0]});
        if (int'(level) > max_level) max_level = int'(level);
    endtask

    // One clock: drive inputs, clock edge, update model, check 1 time unit later.
    task automatic step(input bit rst, input bit w, input logic [25:0] a,
                        input logic [31:0] d, input logic [3:0] be, input bit ack);
        reset          = rst;
        in_write       = w;
        in_addr        = a;
        in_data        = d;
        in_byte_enable = be;
        out_ack        = ack;
        @(posedge clock);
        model_edge(rst, w, a, d, be, ack);
        #1;
        check_all();
    endtask

    task automatic idle_step(input bit ack);
        step(1'b0, 1'b0, 26'h0, 32'h0, 4'h0, ack);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((q.size() != 0 || m_stg_v || m_req) && k < 400) begin
            idle_step(1'b1);
            k++;
        end
        check(tag, 64'(level), 64'd0);
    endtask

    // Fill 20 entries, then ack continuously and count the unbroken request run.
    task automatic burst(input string tag, input logic [25:0] base);
        int run = 0;
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, base + 26'(i), 32'h1000_0000 + 32'(i), 4'hF, 1'b0);
        idle_step(1'b0);
        idle_step(1'b0);
        for (int k = 0; k < 40; k++) begin
            if (out_req) run++;
            else if (run > 0) break;
            idle_step(1'b1);
        end
        check(tag, 64'(run), 64'd20);
    endtask

    initial begin
        int lat;
        int first_full;
        int outs;
        logic [31:0] cap_data;
        logic [3:0]  cap_be;

        reset = 1'b1; in_write = 1'b0; in_addr = 26'h0; in_data = 32'h0;
        in_byte_enable = 4'h0; out_ack = 1'b0;
        m_req = 1'b0; m_ovf = 1'b0; m_stg_v = 1'b0; m_stg = '0;

        // Reset state
        step(1'b1, 1'b0, 26'h0, 32'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 26'h0, 32'h0, 4'h0, 1'b0);
        check("rst_idle", 64'(idle), 64'd1);

        // 1) single write latency with ack held
        step(1'b0, 1'b1, 26'h100, 32'hDEADBEEF, 4'hF, 1'b1);
        lat = 1;
        while (!out_req && lat < 10) begin
            idle_step(1'b1);
            lat++;
        end
        check("t1_latency", 64'(lat), 64'(2 + STG));
        check("t1_addr", 64'(out_addr), 64'h100);
        check("t1_data", 64'(out_data), 64'hDEADBEEF);
        check("t1_be", 64'(out_byte_enable), 64'hF);
        idle_step(1'b1);
        check("t1_req_drop", 64'(out_req), 64'd0);
        check("t1_idle", 64'(idle), 64'd1);

        // 2) fill to capacity, early full, overflow
        first_full = -1;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b1, 26'(i), $urandom, 4'($urandom), 1'b0);
            if (fifo_full && first_full < 0) first_full = q.size();
        end
        idle_step(1'b0);
        check("t2_full_level", 64'(first_full), 64'(248 - STG));
        check("t2_level", 64'(level), 64'd255);
        check("t2_overflow", 64'(overflow), 64'd1);
        drain("t2_drained");

        // 5) reset mid-operation (overflow still set from above)
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 26'h2000 + 26'(i), $urandom, 4'hF, 1'b0);
        idle_step(1'b0);
        idle_step(1'b0);
        check("t5_pre_req", 64'(out_req), 64'd1);
        step(1'b1, 1'b0, 26'h0, 32'h0, 4'h0, 1'b1);
        check("t5_req", 64'(out_req), 64'd0);
        check("t5_level", 64'(level), 64'd0);
        check("t5_idle", 64'(idle), 64'd1);
        check("t5_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 5; i++) idle_step(1'b1);
        check("t5_no_stale", 64'(out_req), 64'd0);

        // 3) back-to-back drain, then again across the pointer wrap
        burst("t3_run", 26'h3000);
        for (int i = 0; i < 250; i++)
            step(1'b0, 1'b1, 26'h4000 + 26'(i), $urandom, 4'hF, 1'b1);
        drain("t3_pre_wrap");
        burst("t3_run_wrap", 26'h5000);

        // 4) random push/ack traffic
        for (int i = 0; i < 1000; i++) begin
            bit w;
            logic [25:0] a;
            w = !model_full() && ($urandom_range(0, 9) < 6);
            a = ($urandom_range(0, 3) == 0) ? 26'($urandom_range(0, 3)) : 26'($urandom);
            step(1'b0, w, a, $urandom, 4'($urandom), $urandom_range(0, 9) < 7);
        end
        drain("t4_drained");
        check("t4_max_level", 64'(max_level > 255), 64'd0);

        // 6) two writes to the same word
        step(1'b1, 1'b0, 26'h0, 32'h0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 26'h40, 32'h000000AA, 4'h1, 1'b1);
        step(1'b0, 1'b1, 26'h40, 32'h00BB0000, 4'h4, 1'b1);
        outs = 0; cap_data = 32'h0; cap_be = 4'h0;
        for (int k = 0; k < 8; k++) begin
            if (out_req) begin
                if (outs == 0) begin
                    cap_data = out_data;
                    cap_be   = out_byte_enable;
                end
                outs++;
            end
            idle_step(1'b1);
        end
        check("t6_outputs", 64'(outs), 64'(2 - STG));
        check("t6_be", 64'(cap_be), (STG == 1) ? 64'h5 : 64'h1);
        check("t6_lane0", 64'(cap_data[7:0]), 64'hAA);
        check("t6_lane2", 64'(cap_data[23:16]), (STG == 1) ? 64'hBB : 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
